// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the image-memory arbiter.
// Grant encoding, default memory geometry and the wait counter width helper.
package mem_arbiter_pkg;

    localparam int unsigned DEF_RAM_WIDTH     = 8;
    localparam int unsigned DEF_RAM_ADDR_BITS = 16;
    localparam int unsigned DEF_MAX_WAIT      = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_HOST = 2'd2
    } grant_t;

    function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_vid_skid.sv
// One-entry holding register for a video read address displaced by a forced host slot.
// Load wins over unload so a served entry can be refilled in the same cycle.
module vid_skid #(
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 unload,
    input  logic [ADDR_BITS-1:0] addr_in,
    output logic                 full,
    output logic [ADDR_BITS-1:0] addr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            addr <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= addr_in;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port image memory between a fixed-latency video read port
// (priority) and a req/ack host port with a starvation-bounded forced slot.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter int unsigned MAX_WAIT      = DEF_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vid_req,
    input  logic [RAM_ADDR_BITS-1:0] vid_addr,
    output logic                     vid_ready,
    output logic                     vid_valid,
    output logic [RAM_WIDTH-1:0]     vid_data,
    output logic                     vid_overflow,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [RAM_ADDR_BITS-1:0] host_addr,
    input  logic [RAM_WIDTH-1:0]     host_wdata,
    output logic                     host_ack,
    output logic [RAM_WIDTH-1:0]     host_rdata,
    output logic                     mem_we,
    output logic [RAM_ADDR_BITS-1:0] mem_addr,
    output logic [RAM_WIDTH-1:0]     mem_di,
    input  logic [RAM_WIDTH-1:0]     mem_do
);

    localparam int unsigned WAIT_W = wait_cnt_width(MAX_WAIT);

    grant_t                   grant;
    logic                     host_busy;
    logic [WAIT_W-1:0]        wait_cnt;
    logic                     host_elig;
    logic                     host_force;
    logic                     skid_full;
    logic [RAM_ADDR_BITS-1:0] skid_addr;
    logic                     skid_load;
    logic                     skid_unload;
    logic                     vid_drop;

    vid_skid #(
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .unload  (skid_unload),
        .addr_in (vid_addr),
        .full    (skid_full),
        .addr    (skid_addr)
    );

    // Grant decision and memory port drive; a forced host slot beats any video.
    always_comb begin
        grant       = GNT_NONE;
        mem_addr    = vid_addr;
        mem_we      = 1'b0;
        mem_di      = host_wdata;
        host_elig   = host_req && !host_busy;
        host_force  = host_elig && (wait_cnt == WAIT_W'(MAX_WAIT));
        vid_ready   = !(skid_full && host_force);
        vid_drop    = vid_req && !vid_ready;
        skid_load   = vid_req && vid_ready && (host_force || skid_full);
        skid_unload = skid_full && !host_force;

        if (host_force) begin
            grant = GNT_HOST;
        end else if (skid_full || vid_req) begin
            grant = GNT_VID;
        end else if (host_elig) begin
            grant = GNT_HOST;
        end

        case (grant)
            GNT_HOST: begin
                mem_addr = host_addr;
                mem_we   = host_we && !reset;
            end
            GNT_VID: begin
                mem_addr = skid_full ? skid_addr : vid_addr;
            end
            default: begin
            end
        endcase
    end

    // Host starvation counter: counts eligible cycles the host was passed over.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!host_req || grant == GNT_HOST) begin
            wait_cnt <= '0;
        end else if (host_elig && wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Registered results; a grant in a reset cycle yields nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_valid    <= 1'b0;
            vid_data     <= '0;
            vid_overflow <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            host_busy    <= 1'b0;
        end else begin
            vid_valid    <= (grant == GNT_VID);
            host_ack     <= (grant == GNT_HOST);
            host_busy    <= (grant == GNT_HOST);
            vid_overflow <= vid_overflow || vid_drop;
            if (grant == GNT_VID) begin
                vid_data <= mem_do;
            end
            if (grant == GNT_HOST && !host_we) begin
                host_rdata <= mem_do;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// starvation/skid sequence, and randomized traffic against a queue-based model.
module tb_mem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ready;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        vid_overflow;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di;
    logic [7:0]  mem_do;

    always #5 clk = ~clk;

    mem_arbiter #(
        .RAM_WIDTH     (8),
        .RAM_ADDR_BITS (16),
        .MAX_WAIT      (MAXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_ready    (vid_ready),
        .vid_valid    (vid_valid),
        .vid_data     (vid_data),
        .vid_overflow (vid_overflow),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_di       (mem_di),
        .mem_do       (mem_do)
    );

    // Memory instance: synchronous write, combinational read.
    logic [7:0] dut_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    assign mem_do = dut_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) dut_mem[mem_addr] <= mem_di;
    end

    int checks = 0;
    int passed = 0;

    function automatic int img(input int a);
        return (a & 255) ^ ((a >> 8) & 255) ^ 'h3C;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic drive(input int r, input int vr, input int va, input int hr,
                         input int hw, input int ha, input int hd);
        reset      = 1'(r);
        vid_req    = 1'(vr);
        vid_addr   = 16'(va);
        host_req   = 1'(hr);
        host_we    = 1'(hw);
        host_addr  = 16'(ha);
        host_wdata = 8'(hd);
    endtask

    typedef struct {
        int rst, vreq, vaddr, hreq, hwe, haddr, hwd;
        int e_ready, e_we, e_addr;
        int e_vv, c_vd, e_vd;
        int e_ack, c_rd, e_rd;
        int e_ovf;
    } vec_t;

    function automatic vec_t mk(input int rst, vreq, vaddr, hreq, hwe, haddr, hwd,
                                e_ready, e_we, e_addr, e_vv, c_vd, e_vd,
                                e_ack, c_rd, e_rd, e_ovf);
        vec_t v;
        v.rst = rst; v.vreq = vreq; v.vaddr = vaddr; v.hreq = hreq; v.hwe = hwe;
        v.haddr = haddr; v.hwd = hwd; v.e_ready = e_ready; v.e_we = e_we;
        v.e_addr = e_addr; v.e_vv = e_vv; v.c_vd = c_vd; v.e_vd = e_vd;
        v.e_ack = e_ack; v.c_rd = c_rd; v.e_rd = e_rd; v.e_ovf = e_ovf;
        return v;
    endfunction

    vec_t tbl [17];
    vec_t v;
    int   s_addr [16];
    int   s_kind [16];

    // Reference model state: pending video addresses in order, host cooldown and wait.
    int   vq [$];
    int   m_wait;
    bit   m_cool;
    bit   m_ovf;
    int   e_vv, e_vd, e_ack, e_rd;
    bit   c_vd, c_rd;

    int   hst, c_hr, c_hw, c_ha, c_hd;
    int   r, vr, va, kind, w_addr, e_addr, e_we, elig, force_h, rdy, drop;

    initial begin
        for (int i = 0; i < 65536; i++) dut_mem[i] = 8'(img(i));

        // Directed vectors: host write/read, lone video, collision, reset during write.
        tbl[0]  = mk(1, 0, 0,   0, 0, 0,      0,    1, 0, 0,      0, 1, 0,       0, 1, 0,         0);
        tbl[1]  = mk(0, 0, 0,   1, 1, 'h1234, 'hA5, 1, 1, 'h1234, 0, 0, 0,       1, 0, 0,         0);
        tbl[2]  = mk(0, 0, 0,   1, 1, 'h1234, 'hA5, 1, 0, 0,      0, 0, 0,       0, 0, 0,         0);
        tbl[3]  = mk(0, 0, 0,   1, 0, 'h1234, 0,    1, 0, 'h1234, 0, 0, 0,       1, 1, 'hA5,      0);
        tbl[4]  = mk(0, 0, 0,   1, 0, 'h1234, 0,    1, 0, 0,      0, 0, 0,       0, 0, 0,         0);
        tbl[5]  = mk(0, 0, 0,   0, 0, 0,      0,    1, 0, 0,      0, 0, 0,       0, 0, 0,         0);
        tbl[6]  = mk(0, 1, 3,   0, 0, 0,      0,    1, 0, 3,      1, 1, img(3),  0, 0, 0,         0);
        tbl[7]  = mk(0, 0, 0,   0, 0, 0,      0,    1, 0, 0,      0, 0, 0,       0, 0, 0,         0);
        tbl[8]  = mk(0, 1, 7,   1, 0, 'h10,   0,    1, 0, 7,      1, 1, img(7),  0, 0, 0,         0);
        tbl[9]  = mk(0, 0, 0,   1, 0, 'h10,   0,    1, 0, 'h10,   0, 0, 0,       1, 1, img('h10), 0);
        tbl[10] = mk(0, 0, 0,   1, 0, 'h10,   0,    1, 0, 0,      0, 0, 0,       0, 0, 0,         0);
        tbl[11] = mk(0, 0, 0,   0, 0, 0,      0,    1, 0, 0,      0, 0, 0,       0, 0, 0,         0);
        tbl[12] = mk(1, 0, 0,   1, 1, 'h20,   'h77, 1, 0, 'h20,   0, 1, 0,       0, 1, 0,         0);
        tbl[13] = mk(0, 0, 0,   0, 0, 0,      0,    1, 0, 0,      0, 1, 0,       0, 1, 0,         0);
        tbl[14] = mk(0, 0, 0,   1, 0, 'h20,   0,    1, 0, 'h20,   0, 0, 0,       1, 1, img('h20), 0);
        tbl[15] = mk(0, 0, 0,   1, 0, 'h20,   0,    1, 0, 0,      0, 0, 0,       0, 0, 0,         0);
        tbl[16] = mk(0, 0, 0,   0, 0, 0,      0,    1, 0, 0,      0, 0, 0,       0, 0, 0,         0);

        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            v = tbl[i];
            drive(v.rst, v.vreq, v.vaddr, v.hreq, v.hwe, v.haddr, v.hwd);
            #2;
            chk($sformatf("tbl%0d vid_ready", i), int'(vid_ready), v.e_ready);
            chk($sformatf("tbl%0d mem_we", i), int'(mem_we), v.e_we);
            chk($sformatf("tbl%0d mem_addr", i), int'(mem_addr), v.e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d vid_valid", i), int'(vid_valid), v.e_vv);
            if (v.c_vd != 0) chk($sformatf("tbl%0d vid_data", i), int'(vid_data), v.e_vd);
            chk($sformatf("tbl%0d host_ack", i), int'(host_ack), v.e_ack);
            if (v.c_rd != 0) chk($sformatf("tbl%0d host_rdata", i), int'(host_rdata), v.e_rd);
            chk($sformatf("tbl%0d vid_overflow", i), int'(vid_overflow), v.e_ovf);
        end

        // Continuous video with two host requests: forced slot at 4, skid, then drop at 10.
        s_addr = '{0, 1, 2, 3, 'h40, 4, 5, 6, 7, 8, 'h41, 9, 11, 12, 13, 0};
        s_kind = '{1, 1, 1, 1, 2,    1, 1, 1, 1, 1, 2,    1, 1,  1,  1,  0};
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 16; c++) begin
            drive(0, (c < 14) ? 1 : 0, (c < 14) ? c : 0, (c <= 11) ? 1 : 0, 0,
                  (c <= 5) ? 'h40 : 'h41, 0);
            #2;
            chk($sformatf("seq%0d vid_ready", c), int'(vid_ready), (c == 10) ? 0 : 1);
            chk($sformatf("seq%0d mem_addr", c), int'(mem_addr), s_addr[c]);
            chk($sformatf("seq%0d mem_we", c), int'(mem_we), 0);
            @(posedge clk);
            #1;
            chk($sformatf("seq%0d vid_valid", c), int'(vid_valid), (s_kind[c] == 1) ? 1 : 0);
            if (s_kind[c] == 1) chk($sformatf("seq%0d vid_data", c), int'(vid_data), img(s_addr[c]));
            chk($sformatf("seq%0d host_ack", c), int'(host_ack), (s_kind[c] == 2) ? 1 : 0);
            if (s_kind[c] == 2) chk($sformatf("seq%0d host_rdata", c), int'(host_rdata), img(s_addr[c]));
            chk($sformatf("seq%0d vid_overflow", c), int'(vid_overflow), (c >= 10) ? 1 : 0);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("seq overflow cleared by reset", int'(vid_overflow), 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 65536; i++) begin
            dut_mem[i] = 8'(img(i));
            ref_mem[i] = 8'(img(i));
        end
        vq.delete();
        m_wait = 0; m_cool = 0; m_ovf = 0;
        hst = 0; c_hr = 0; c_hw = 0; c_ha = 0; c_hd = 0;

        for (int n = 0; n < 3000; n++) begin
            if (hst == 1 && host_ack) hst = 2;
            else if (hst == 2) hst = 0;
            if (hst == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    c_hr = 1;
                    c_hw = int'($urandom_range(0, 1));
                    c_ha = int'($urandom_range(0, 63));
                    c_hd = int'($urandom_range(0, 255));
                    hst  = 1;
                end else begin
                    c_hr = 0;
                end
            end
            r  = (n < 2 || $urandom_range(0, 199) == 0) ? 1 : 0;
            vr = ($urandom_range(0, 9) < 6) ? 1 : 0;
            va = int'($urandom_range(0, 63));
            drive(r, vr, va, c_hr, c_hw, c_ha, c_hd);

            elig    = (c_hr != 0 && !m_cool) ? 1 : 0;
            force_h = (elig != 0 && m_wait == MAXW) ? 1 : 0;
            rdy     = (vq.size() != 0 && force_h != 0) ? 0 : 1;
            drop    = (vr != 0 && rdy == 0) ? 1 : 0;
            if (vr != 0 && rdy != 0) vq.push_back(va);
            w_addr = 0;
            if (force_h != 0) kind = 2;
            else if (vq.size() != 0) begin kind = 1; w_addr = vq.pop_front(); end
            else if (elig != 0) kind = 2;
            else kind = 0;
            e_addr = (kind == 2) ? c_ha : ((kind == 1) ? w_addr : va);
            e_we   = (kind == 2 && c_hw != 0 && r == 0) ? 1 : 0;

            #2;
            chk("rnd vid_ready", int'(vid_ready), rdy);
            chk("rnd mem_we", int'(mem_we), e_we);
            chk("rnd mem_addr", int'(mem_addr), e_addr);
            @(posedge clk);

            if (r != 0) begin
                vq.delete();
                m_wait = 0; m_cool = 0; m_ovf = 0;
                e_vv = 0; e_vd = 0; e_ack = 0; e_rd = 0;
                c_vd = 1; c_rd = 1;
            end else begin
                e_vv = (kind == 1) ? 1 : 0;
                c_vd = (kind == 1);
                if (kind == 1) e_vd = int'(ref_mem[w_addr]);
                e_ack = (kind == 2) ? 1 : 0;
                c_rd  = (kind == 2 && c_hw == 0);
                if (c_rd) e_rd = int'(ref_mem[c_ha]);
                if (kind == 2 && c_hw != 0) ref_mem[c_ha] = 8'(c_hd);
                if (c_hr == 0 || kind == 2) m_wait = 0;
                else if (elig != 0 && m_wait < MAXW) m_wait = m_wait + 1;
                m_cool = (kind == 2);
                m_ovf  = m_ovf || (drop != 0);
            end

            #1;
            chk("rnd vid_valid", int'(vid_valid), e_vv);
            if (c_vd) chk("rnd vid_data", int'(vid_data), e_vd);
            chk("rnd host_ack", int'(host_ack), e_ack);
            if (c_rd) chk("rnd host_rdata", int'(host_rdata), e_rd);
            chk("rnd vid_overflow", int'(vid_overflow), int'(m_ovf));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
